// File: rtl/imul_sequential_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// counter sizing and the operand magnitude helper.
package imul_sequential_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAX_SIZE = 32;

  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction

  // Operands are zero-extended to MAX_SIZE by the caller and truncated back afterwards.
  function automatic logic [MAX_SIZE-1:0] cond_negate(input logic [MAX_SIZE-1:0] value,
                                                      input logic               negate);
    return negate ? (MAX_SIZE'(0) - value) : value;
  endfunction

endpackage

// File: rtl/FULL_ADDER.sv
// Parametrised ripple adder shared across the datapath; carry-in and carry-out
// are exposed so wider sums can be chained.
module FULL_ADDER #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Ci,
  output logic [SIZE-1:0] S,
  output logic            Co
);

  assign {Co, S} = {1'b0, A} + {1'b0, B} + {{SIZE{1'b0}}, Ci};

endmodule

// File: rtl/imul_sequential.sv
// Iterative radix-2 shift-add multiplier: one adder reused for SIZE steps,
// then a sign-fix cycle. Start/Busy/Done handshake, per-operation signed mode.
module imul_sequential
  import imul_sequential_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Signed,
  input  logic [SIZE-1:0]   MulA,
  input  logic [SIZE-1:0]   MulB,
  output logic              Busy,
  output logic              Done,
  output logic [2*SIZE-1:0] Product
);

  localparam int CNT_W = cnt_width(SIZE);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     mcand_q, mcand_d;
  logic [SIZE-1:0]     mplier_q, mplier_d;
  logic [SIZE:0]       acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*SIZE-1:0]   product_q, product_d;
  logic                done_q, done_d;

  logic [SIZE-1:0]     addend;
  logic [SIZE-1:0]     add_sum;
  logic                add_co;
  logic [SIZE:0]       step_sum;
  logic [2*SIZE-1:0]   raw;

  assign addend = mplier_q[0] ? mcand_q : '0;

  FULL_ADDER #(.SIZE(SIZE)) u_step_adder (
    .A  (acc_q[SIZE-1:0]),
    .B  (addend),
    .Ci (1'b0),
    .S  (add_sum),
    .Co (add_co)
  );

  // Full SIZE+1-bit sum: the addend has no bit SIZE, so the top bit is acc MSB xor carry.
  assign step_sum = {acc_q[SIZE] ^ add_co, add_sum};
  assign raw      = {acc_q[SIZE-1:0], mplier_q};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          neg_d    = Signed & (MulA[SIZE-1] ^ MulB[SIZE-1]);
          mcand_d  = SIZE'(cond_negate(MAX_SIZE'(MulA), Signed & MulA[SIZE-1]));
          mplier_d = SIZE'(cond_negate(MAX_SIZE'(MulB), Signed & MulB[SIZE-1]));
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = {1'b0, step_sum[SIZE:1]};
        mplier_d = {step_sum[0], mplier_q[SIZE-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SIZE - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = neg_q ? ('0 - raw) : raw;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_imul_sequential.sv
// Scoreboard bench for imul_sequential at SIZE = 8: expected products are queued
// when an operation is launched and checked on every Done pulse.
module tb_imul_sequential;

  localparam int SIZE = 8;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Signed;
  logic [SIZE-1:0]   MulA;
  logic [SIZE-1:0]   MulB;
  logic              Busy;
  logic              Done;
  logic [2*SIZE-1:0] Product;

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneCount     = 0;
  int expectedDones = 0;
  logic [2*SIZE-1:0] expectQ[$];

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  always #5 Clock = ~Clock;

  imul_sequential #(.SIZE(SIZE)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Signed  (Signed),
    .MulA    (MulA),
    .MulB    (MulB),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every Done pulse retires the oldest queued expectation.
  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      doneCount++;
      if (expectQ.size() == 0)
        checkOutput("spuriousDone", 32'(Done), 32'd0);
      else
        checkOutput("product", 32'(Product), 32'(expectQ.pop_front()));
    end
  end

  // Called at a falling edge; returns at the falling edge just after the sampling edge.
  task automatic applyStimulus(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expected, input logic holdStart);
    Signed = sgn;
    MulA   = a;
    MulB   = b;
    Start  = 1'b1;
    expectQ.push_back(expected);
    expectedDones++;
    @(posedge Clock);
    @(negedge Clock);
    if (!holdStart) Start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLatency, output int busyCycles);
    int cycles;
    cycles     = 0;
    busyCycles = 0;
    while (Done !== 1'b1 && cycles < 40) begin
      if (Busy === 1'b1) busyCycles++;
      @(negedge Clock);
      cycles++;
    end
    checkOutput({tag, "Latency"}, 32'(cycles), 32'(expLatency));
    checkOutput({tag, "BusyInDone"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int busyCycles;

    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
    vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{1'b1, 8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{1'b0, 8'h03, 8'hFB, 16'h02F1};
    vecs[6] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

    Reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    MulA   = '0;
    MulB   = '0;
    repeat (2) @(negedge Clock);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetDone", 32'(Done), 32'd0);
    checkOutput("resetProduct", 32'(Product), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    $display("[TB] unsigned 255 x 255");
    applyStimulus(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    checkOutput("busyAfterStart", 32'(Busy), 32'd1);
    waitDone("mul255", SIZE + 1, busyCycles);
    checkOutput("busyCycles255", 32'(busyCycles), 32'(SIZE + 1));

    $display("[TB] operand table, each launched in the previous Done cycle");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
      waitDone("table", SIZE + 1, busyCycles);
    end

    $display("[TB] Start re-pulsed while busy");
    applyStimulus(1'b0, 8'h0C, 8'h0D, 16'h009C, 1'b0);
    repeat (2) @(negedge Clock);
    Start  = 1'b1;
    Signed = 1'b1;
    MulA   = 8'hFF;
    MulB   = 8'h80;
    @(negedge Clock);
    Start  = 1'b0;
    MulA   = 8'h55;
    waitDone("repulse", SIZE - 2, busyCycles);
    repeat (12) @(negedge Clock);
    checkOutput("repulseDoneCount", 32'(doneCount), 32'(expectedDones));

    $display("[TB] Start held through the Done cycle");
    applyStimulus(1'b1, 8'hFA, 8'h07, 16'hFFD6, 1'b1);
    Signed = 1'b0;
    MulA   = 8'h11;
    MulB   = 8'h13;
    waitDone("b2bFirst", SIZE + 1, busyCycles);
    expectQ.push_back(16'h0143);
    expectedDones++;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("b2bSecondBusy", 32'(Busy), 32'd1);
    repeat (3) @(negedge Clock);
    checkOutput("holdBetweenDones", 32'(Product), 32'h0000FFD6);
    waitDone("b2bSecond", SIZE - 2, busyCycles);

    $display("[TB] reset during RUN");
    applyStimulus(1'b0, 8'hC8, 8'h64, 16'h4E20, 1'b0);
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    checkOutput("abortBusy", 32'(Busy), 32'd0);
    checkOutput("abortDone", 32'(Done), 32'd0);
    checkOutput("abortProduct", 32'(Product), 32'd0);
    void'(expectQ.pop_back());
    expectedDones--;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (15) @(negedge Clock);
    checkOutput("noDoneAfterAbort", 32'(doneCount), 32'(expectedDones));
    applyStimulus(1'b0, 8'd7, 8'd6, 16'd42, 1'b0);
    waitDone("afterReset", SIZE + 1, busyCycles);

    repeat (3) @(negedge Clock);
    checkOutput("doneTotal", 32'(doneCount), 32'(expectedDones));
    checkOutput("queueEmpty", 32'(expectQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
